spi_controller_tx: RTL

- SPI mode-0 write initiator: the controller end of the same 16-bit register-write protocol that the on-chip SPI peripheral decodes.
- Takes a parallel {rw, addr, data} request over a valid/ready handshake and serialises it MSB-first onto nCS/SCLK/COPI.
- Used by the test harness and by any future on-chip master to program the PWM/output-enable registers.

---
 rtl/spi_pkg.sv | 12 +
 rtl/spi_sclk_gen.sv | 30 +++
 rtl/spi_controller_tx.sv | 99 +++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: frame geometry, register map and controller states shared by the SPI controller and peripheral
package spi_pkg;
  localparam int SPI_FRAME_W = 16;
  localparam int SPI_ADDR_W = 7;
  localparam int SPI_DATA_W = 8;
  localparam logic [SPI_ADDR_W-1:0] ADDR_EN_OUT_7_0 = 7'h00;
  localparam logic [SPI_ADDR_W-1:0] ADDR_EN_OUT_15_8 = 7'h01;
  localparam logic [SPI_ADDR_W-1:0] ADDR_EN_PWM_7_0 = 7'h02;
  localparam logic [SPI_ADDR_W-1:0] ADDR_EN_PWM_15_8 = 7'h03;
  localparam logic [SPI_ADDR_W-1:0] ADDR_PWM_DUTY = 7'h04;
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_TAIL, ST_GAP} spi_state_e;
endpackage

// File: rtl/spi_sclk_gen.sv
// spi_sclk_gen: phase counter emitting alternating rise/fall strobes every CLK_DIV cycles while enabled
module spi_sclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic rise_o,
  output logic fall_o,
  output logic near_o
);
  localparam int PW = $clog2(CLK_DIV);
  logic [PW-1:0] cnt_q;
  logic lvl_q;
  logic tick;
  assign tick = en_i && cnt_q == PW'(CLK_DIV - 1);
  assign rise_o = tick && !lvl_q;
  assign fall_o = tick && lvl_q;
  // one cycle before the strobe, lets the owner register a pulse aligned with it
  assign near_o = en_i && cnt_q == PW'(CLK_DIV - 2);
  always_ff @(posedge clk) begin
    if (rst || !en_i) begin
      cnt_q <= '0;
      lvl_q <= 1'b0;
    end else begin
      cnt_q <= tick ? '0 : cnt_q + 1'b1;
      lvl_q <= lvl_q ^ tick;
    end
  end
endmodule

// File: rtl/spi_controller_tx.sv
// spi_controller_tx: mode-0 SPI write initiator serialising {rw, addr, data} MSB-first
module spi_controller_tx
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int ADDR_W = SPI_ADDR_W,
  parameter int DATA_W = SPI_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic              ncs,
  output logic              sclk,
  output logic              copi,
  output logic              busy,
  output logic              done
);
  localparam int FW = 1 + ADDR_W + DATA_W;
  spi_state_e state_q, state_d;
  logic [FW-1:0] sh_q, sh_d;
  logic [4:0] bit_q, bit_d;
  logic sclk_q, sclk_d, ncs_q, ncs_d, copi_q, copi_d, busy_q, busy_d, done_q, done_d;
  logic rise, fall, near;
  spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .clk(clk), .rst(rst), .en_i(busy_q), .rise_o(rise), .fall_o(fall), .near_o(near)
  );
  always_comb begin
    state_d = state_q;
    sh_d = sh_q;
    bit_d = bit_q;
    sclk_d = sclk_q;
    ncs_d = ncs_q;
    copi_d = copi_q;
    busy_d = busy_q;
    done_d = 1'b0;
    case (state_q)
      ST_IDLE: if (req_valid) begin
        state_d = ST_SHIFT;
        sh_d = {req_rw, req_addr, req_data};
        bit_d = '0;
        copi_d = req_rw;
        ncs_d = 1'b0;
        busy_d = 1'b1;
      end
      ST_SHIFT: if (rise) sclk_d = 1'b1;
        else if (fall) begin
          sclk_d = 1'b0;
          state_d = bit_q == 5'(FW - 1) ? ST_TAIL : ST_SHIFT;
          bit_d = bit_q == 5'(FW - 1) ? bit_q : bit_q + 5'd1;
          sh_d = bit_q == 5'(FW - 1) ? sh_q : sh_q << 1;
          copi_d = bit_q == 5'(FW - 1) ? copi_q : sh_q[FW-2];
        end
      ST_TAIL: if (rise || fall) begin
        state_d = ST_GAP;
        ncs_d = 1'b1;
        copi_d = 1'b0;
      end
      ST_GAP: begin
        done_d = near;
        if (rise || fall) begin
          state_d = ST_IDLE;
          busy_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sh_q <= '0;
      bit_q <= '0;
      sclk_q <= 1'b0;
      ncs_q <= 1'b1;
      copi_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q <= sh_d;
      bit_q <= bit_d;
      sclk_q <= sclk_d;
      ncs_q <= ncs_d;
      copi_q <= copi_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign req_ready = !busy_q;
  assign ncs = ncs_q;
  assign sclk = sclk_q;
  assign copi = copi_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule
